systolic_feeder: RTL and testbench

//  Operand scheduler in front of the 3x3 output-stationary systolic array.

---
 rtl/systolic_feeder.sv | 166 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: operand scheduler for an NxN output-stationary systolic array.
// Holds one A and one B matrix, loaded element by element over a valid/ready
// port while idle. On start it presents row-skewed A rows on the array's left
// edge and column-skewed B columns on its top edge, with en high, then drains
// and pulses done for one cycle.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   ld_valid/ld_ready load handshake (ready only while idle)
//   ld_sel            0 = A buffer, 1 = B buffer
//   ld_row/ld_col     element index; indices >= N are accepted and dropped
//   ld_data           element value
//   start             begin a feed sequence (honoured in idle only)
//   busy, done        run status / one-cycle completion pulse
//   a_flat, b_flat    slice i = left input of row i / top input of column i
//   en                array enable

// One edge lane: emits vec[k] when the slot index equals LANE+k, else zero.
module sf_lane #(
  parameter int N    = 3,
  parameter int DW   = 32,
  parameter int CW   = 4,
  parameter int LANE = 0
) (
  input  logic [CW-1:0]        ts,
  input  logic [N-1:0][DW-1:0] vec,
  output logic [DW-1:0]        slice
);
  always_comb begin
    slice = '0;
    for (int k = 0; k < N; k++)
      if (int'(ts) == LANE + k) slice = vec[k];
  end
endmodule

module systolic_feeder #(
  parameter int N     = 3,
  parameter int DW    = 32,
  parameter int DRAIN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_sel,
  input  logic [1:0]    ld_row,
  input  logic [1:0]    ld_col,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [N*DW-1:0] a_flat,
  output logic [N*DW-1:0] b_flat,
  output logic          en
);
  localparam int FEED_LEN = 3*N - 2;
  localparam int CW       = $clog2(FEED_LEN + DRAIN + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;
  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

  state_t               state;
  logic [CW-1:0]        cnt, ts;
  mat_t                 a_buf, b_buf, a_nx, b_nx, b_col;
  logic [N-1:0][DW-1:0] a_sl, b_sl;
  logic                 wr;

  // ld_ready is only high in idle, so an accepted load never races a run.
  assign wr = ld_valid & ld_ready;

  // Buffers with this cycle's write folded in, so a load accepted in the
  // same cycle as start is already visible in slot 0.
  always_comb begin
    a_nx = a_buf;
    b_nx = b_buf;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (wr && int'(ld_row) == i && int'(ld_col) == j) begin
          if (ld_sel) b_nx[i][j] = ld_data;
          else        a_nx[i][j] = ld_data;
        end
  end

  // Column view of B so both edges use the same lane shape.
  always_comb begin
    b_col = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        b_col[j][k] = b_nx[k][j];
  end

  // Outputs are registered, so lanes compute the slot about to be presented.
  assign ts = (state == S_IDLE) ? '0 : cnt + CW'(1);

  for (genvar g = 0; g < N; g++) begin : g_lane
    sf_lane #(.N(N), .DW(DW), .CW(CW), .LANE(g)) u_a (
      .ts(ts), .vec(a_nx[g]), .slice(a_sl[g]));
    sf_lane #(.N(N), .DW(DW), .CW(CW), .LANE(g)) u_b (
      .ts(ts), .vec(b_col[g]), .slice(b_sl[g]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_buf    <= '0;
      b_buf    <= '0;
      a_flat   <= '0;
      b_flat   <= '0;
      en       <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ld_ready <= 1'b0;
    end else begin
      a_buf <= a_nx;
      b_buf <= b_nx;
      case (state)
        S_IDLE: begin
          ld_ready <= 1'b1;
          if (start) begin
            state    <= S_FEED;
            cnt      <= '0;
            ld_ready <= 1'b0;
            busy     <= 1'b1;
            en       <= 1'b1;
            a_flat   <= a_sl;
            b_flat   <= b_sl;
          end
        end
        S_FEED: begin
          if (int'(cnt) == FEED_LEN - 1) begin
            cnt    <= '0;
            a_flat <= '0;
            b_flat <= '0;
            if (DRAIN > 0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_DONE;
              en    <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt    <= cnt + CW'(1);
            a_flat <= a_sl;
            b_flat <= b_sl;
          end
        end
        S_DRAIN: begin
          if (int'(cnt) == DRAIN - 1) begin
            state <= S_DONE;
            en    <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          ld_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: cycle tables for the skewed feed, a behavioural
// 3x3 output-stationary array downstream to check accumulated products, and
// hand sequences for same-cycle load/start, out-of-range loads and reset.
module tb_systolic_feeder;
  localparam int N  = 3;
  localparam int DW = 32;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          ld_valid = 1'b0, ld_sel = 1'b0, start = 1'b0;
  logic [1:0]    ld_row = '0, ld_col = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, busy, done, en;
  logic [N*DW-1:0] a_flat, b_flat;

  systolic_feeder #(.N(N), .DW(DW), .DRAIN(1)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_sel(ld_sel), .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .a_flat(a_flat),
    .b_flat(b_flat), .en(en));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [N*DW-1:0] act,
                     input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) if (done) done_cnt++;

  // Behavioural output-stationary array fed by the DUT.
  logic [DW-1:0] ar[N][N], br[N][N], cm[N][N];
  logic [DW-1:0] al, bt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ar[i][j] <= '0; br[i][j] <= '0; cm[i][j] <= '0;
        end
    end else if (en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) al = a_flat[i*DW +: DW]; else al = ar[i][j-1];
          if (i == 0) bt = b_flat[j*DW +: DW]; else bt = br[i-1][j];
          cm[i][j] <= cm[i][j] + al * bt;
          ar[i][j] <= al;
          br[i][j] <= bt;
        end
    end
  end

  typedef struct {
    logic start, ldv;
    logic [DW-1:0] a0, a1, a2, b0, b1, b2;
    logic en, busy, done, rdy;
  } vec_t;
  vec_t tbl[10];

  task automatic set_row(input int r, input int a0, a1, a2, b0, b1, b2,
                         input logic e, bz, dn, rd);
    tbl[r] = '{(r == 0), 1'b0, DW'(a0), DW'(a1), DW'(a2), DW'(b0), DW'(b1),
               DW'(b2), e, bz, dn, rd};
  endtask

  // Table rows: row r drives inputs in cycle r, checks after the edge.
  task automatic run_table(input string tag, input bit noise);
    vec_t v;
    for (int r = 0; r < 10; r++) begin
      v = tbl[r];
      if (noise && (r == 2 || r == 3)) begin v.start = 1'b1; v.ldv = 1'b1; end
      start = v.start; ld_valid = v.ldv;
      ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 32'h55;
      @(posedge clk); #1;
      start = 1'b0; ld_valid = 1'b0;
      chk($sformatf("%s r%0d a0", tag, r), a_flat[0*DW +: DW], v.a0);
      chk($sformatf("%s r%0d a1", tag, r), a_flat[1*DW +: DW], v.a1);
      chk($sformatf("%s r%0d a2", tag, r), a_flat[2*DW +: DW], v.a2);
      chk($sformatf("%s r%0d b0", tag, r), b_flat[0*DW +: DW], v.b0);
      chk($sformatf("%s r%0d b1", tag, r), b_flat[1*DW +: DW], v.b1);
      chk($sformatf("%s r%0d b2", tag, r), b_flat[2*DW +: DW], v.b2);
      chk($sformatf("%s r%0d en", tag, r), en, v.en);
      chk($sformatf("%s r%0d busy", tag, r), busy, v.busy);
      chk($sformatf("%s r%0d done", tag, r), done, v.done);
      chk($sformatf("%s r%0d rdy", tag, r), ld_ready, v.rdy);
    end
  endtask

  task automatic load(input logic sel, input int row, col, input int data);
    chk($sformatf("load rdy %0d/%0d/%0d", sel, row, col), ld_ready, 1'b1);
    ld_valid = 1'b1; ld_sel = sel;
    ld_row = 2'(row); ld_col = 2'(col); ld_data = DW'(data);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, " done seen"}, done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_c(input string tag, input int m);
    int ce[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s C%0d", tag, k), cm[k/3][k%3], DW'(ce[k] * m));
  endtask

  int am[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int bm[9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  int dsave;

  initial begin
    set_row(0, 1, 0, 0, 9, 0, 0, 1, 1, 0, 0);
    set_row(1, 2, 4, 0, 6, 8, 0, 1, 1, 0, 0);
    set_row(2, 3, 5, 7, 3, 5, 7, 1, 1, 0, 0);
    set_row(3, 0, 6, 8, 0, 2, 4, 1, 1, 0, 0);
    set_row(4, 0, 0, 9, 0, 0, 1, 1, 1, 0, 0);
    set_row(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    set_row(6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    set_row(7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    set_row(8, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    set_row(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset state.
    repeat (2) @(posedge clk); #1;
    chk("rst rdy", ld_ready, 1'b0);
    chk("rst en", en, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst a", a_flat, '0);
    chk("rst b", b_flat, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst rdy", ld_ready, 1'b1);

    for (int k = 0; k < 9; k++) load(1'b0, k/3, k%3, am[k]);
    for (int k = 0; k < 9; k++) load(1'b1, k/3, k%3, bm[k]);
    chk("idle a", a_flat, '0);
    chk("idle en", en, 1'b0);

    run_table("run1", 1'b0);
    check_c("run1", 1);
    run_table("run2", 1'b0);
    check_c("run2", 2);

    // start/load pulsed mid-feed must be ignored.
    run_table("noise", 1'b1);
    check_c("noise", 3);
    run_table("after-noise", 1'b0);

    // Out-of-range indices complete the handshake and change nothing.
    load(1'b0, 3, 0, 32'hDEAD);
    load(1'b1, 0, 3, 32'hDEAD);
    run_table("oor", 1'b0);

    // Load in the same cycle as start is used by that run.
    ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0;
    ld_data = 32'd11; start = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0; start = 1'b0;
    chk("same-cyc a0", a_flat[0 +: DW], 32'd11);
    chk("same-cyc b0", b_flat[0 +: DW], 32'd9);
    chk("same-cyc en", en, 1'b1);
    wait_done("same-cyc");

    // Reset in the fourth feed cycle aborts at once.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("pre-abort en", en, 1'b1);
    chk("pre-abort a1", a_flat[1*DW +: DW], 32'd6);
    dsave = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("abort a", a_flat, '0);
    chk("abort b", b_flat, '0);
    chk("abort en", en, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort rdy", ld_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("abort no done", done_cnt, dsave);
    chk("abort rdy after", ld_ready, 1'b1);

    // Buffers were cleared: a fresh run feeds only zeros.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero-run en", en, 1'b1);
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("zero-run a c%0d", c), a_flat, '0);
      chk($sformatf("zero-run b c%0d", c), b_flat, '0);
      @(posedge clk); #1;
    end
    wait_done("zero-run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
